// File: rtl/uart_rx_pkg.sv
// Shared UART constants: line-rate defaults, frame shape and parity helper.
// Used by both the receive and transmit sides of the link.
package uart_rx_pkg;

    localparam int DEF_BAUD    = 9600;
    localparam int DEF_SYS_CLK = 50_000_000;
    localparam int DATA_BITS   = 8;
    localparam bit PARITY_ODD  = 1'b1;

    function automatic int baud_max(input int sys_clk, input int baud);
        return sys_clk / baud - 1;
    endfunction

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return PARITY_ODD ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Reset value is a parameter so idle-high lines come out of reset idle.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data LSB-first, odd parity, 1 stop.
// Delivers every frame with a 1-cycle strobe plus parity/frame error flags.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD    = DEF_BAUD,
    parameter int SYS_CLK = DEF_SYS_CLK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_data,
    output logic [7:0] out_data,
    output logic       out_en,
    output logic       out_err_parity,
    output logic       out_err_frame
);

    localparam int MAX   = baud_max(SYS_CLK, BAUD);
    localparam int HALF  = MAX / 2;
    localparam int WIDTH = $clog2(MAX + 1);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] CNT_HALF = WIDTH'(HALF);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic rx_s;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in_data),
        .q     (rx_s)
    );

    state_t                 state_q,     state_d;
    logic [WIDTH-1:0]       cnt_q,       cnt_d;
    logic [IDX_W-1:0]       bit_idx_q,   bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q,     shift_d;
    logic                   par_q,       par_d;
    logic                   rx_prev_q,   rx_prev_d;
    logic [7:0]             out_data_q,  out_data_d;
    logic                   out_en_q,    out_en_d;
    logic                   err_par_q,   err_par_d;
    logic                   err_frm_q,   err_frm_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        rx_prev_d  = rx_s;
        out_data_d = out_data_q;
        out_en_d   = 1'b0;
        err_par_d  = 1'b0;
        err_frm_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_MAX) begin
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_MAX) begin
                    par_d   = rx_s;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_MAX) begin
                    out_en_d   = 1'b1;
                    out_data_d = shift_q;
                    err_par_d  = par_q != parity_of(shift_q);
                    err_frm_d  = !rx_s;
                    // idling at the stop mid-sample leaves margin for a back-to-back start
                    state_d    = rx_s ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            rx_prev_q  <= 1'b1;
            out_data_q <= '0;
            out_en_q   <= 1'b0;
            err_par_q  <= 1'b0;
            err_frm_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            rx_prev_q  <= rx_prev_d;
            out_data_q <= out_data_d;
            out_en_q   <= out_en_d;
            err_par_q  <= err_par_d;
            err_frm_q  <= err_frm_d;
        end
    end

    assign out_data       = out_data_q;
    assign out_en         = out_en_q;
    assign out_err_parity = err_par_q;
    assign out_err_frame  = err_frm_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames
// checked against a frame-level reference model.
module tb_uart_rx;

    localparam int SYS_CLK = 1_000_000;
    localparam int BAUD    = 100_000;
    localparam int BIT     = SYS_CLK / BAUD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_data = 1'b1;
    logic [7:0] out_data;
    logic       out_en;
    logic       out_err_parity;
    logic       out_err_frame;

    uart_rx #(.BAUD(BAUD), .SYS_CLK(SYS_CLK)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .out_data       (out_data),
        .out_en         (out_en),
        .out_err_parity (out_err_parity),
        .out_err_frame  (out_err_frame)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         cyc;
    } rec_t;

    rec_t got_q[$];
    rec_t exp_q[$];
    int   cyc = 0;
    bit   leak = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] last_d;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_en)
            got_q.push_back('{out_data, out_err_parity, out_err_frame, cyc});
        else if (out_err_parity || out_err_frame)
            leak = 1'b1;
    end

    // Reference: a frame is good when data+parity hold an odd number of ones
    function automatic rec_t model(input logic [7:0] d, input logic par,
                                   input logic stop);
        rec_t r;
        r.d   = d;
        r.pe  = ($countones({d, par}) % 2) == 0;
        r.fe  = !stop;
        r.cyc = 0;
        return r;
    endfunction

    function automatic logic good_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic line(input logic b, input int n);
        in_data = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic par,
                        input logic stop);
        line(1'b0, BIT);
        for (int i = 0; i < 8; i++) line(d[i], BIT);
        line(par, BIT);
        line(stop, BIT);
        exp_q.push_back(model(d, par, stop));
        last_d = d;
    endtask

    task automatic check_frames(input string tag);
        rec_t g;
        rec_t e;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_data"}, g.d, e.d);
            chk({tag, "_perr"}, g.pe, e.pe);
            chk({tag, "_ferr"}, g.fe, e.fe);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_data"}, out_data, 8'h00);
        chk({tag, "_en"}, out_en, 1'b0);
        chk({tag, "_perr"}, out_err_parity, 1'b0);
        chk({tag, "_ferr"}, out_err_frame, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;

        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst_n = 1'b1;
        line(1'b1, 20);

        send(8'h55, good_par(8'h55), 1'b1);
        line(1'b1, 20);
        check_frames("t1_55");

        send(8'hA5, 1'b0, 1'b1);
        line(1'b1, 20);
        check_frames("t2_par");

        send(8'h3C, good_par(8'h3C), 1'b0);
        line(1'b0, 50);
        check_frames("t3_break");
        line(1'b1, 30);
        chk("t3_no_second", got_q.size(), 0);

        line(1'b0, 3);
        line(1'b1, 30);
        chk("t4_glitch", got_q.size(), 0);
        send(8'h81, good_par(8'h81), 1'b1);
        line(1'b1, 20);
        check_frames("t4_81");

        send(8'h00, good_par(8'h00), 1'b1);
        send(8'hFF, good_par(8'hFF), 1'b1);
        line(1'b1, 20);
        chk("t5_strobes", got_q.size(), 2);
        if (got_q.size() == 2)
            chk("t5_gap", got_q[1].cyc - got_q[0].cyc, 110);
        check_frames("t5_b2b");
        chk("t5_hold", out_data, 8'hFF);

        d = 8'h7E;
        line(1'b0, BIT);
        for (int i = 0; i < 4; i++) line(d[i], BIT);
        line(d[4], 5);
        rst_n = 1'b0;
        in_data = 1'b1;
        @(negedge clk);
        chk_reset_outs("t6_rst");
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        line(1'b1, 40);
        chk("t6_no_strobe", got_q.size(), 0);
        send(8'h12, good_par(8'h12), 1'b1);
        line(1'b1, 20);
        check_frames("t6_12");

        for (int k = 0; k < 12; k++) begin
            d = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
            s = ($urandom_range(0, 4) != 0);
            send(d, p, s);
            line(1'b1, $urandom_range(3, 25));
            check_frames("rnd");
        end

        line(1'b1, 30);
        chk("hold_last", out_data, last_d);
        chk("flag_leak", leak, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
